// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one ALU operation at a time to a 32-bit datapath
// with a 5:1 result mux (0=add, 1=sub, 2=mul, 3=shr, 4=shl). It registers
// the operands and mux select, waits the per-op latency, captures the mux
// output and holds it on a valid/ready result port until the consumer takes it.
module alu_op_sequencer #(
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 4,
  parameter int SH_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  sel,
  input  logic [31:0] mux_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [2:0]  r_sel;
  logic [31:0] r_res_data;
  logic        r_res_err;
  logic [15:0] r_op_count;

  // Opcodes 5..7 have no mux input behind them.
  function automatic logic f_illegal(input logic [2:0] op);
    return (op > 3'd4);
  endfunction

  // Countdown preload: the counter hits zero on the capture edge, LAT edges after accept.
  function automatic logic [7:0] f_lat_m1(input logic [2:0] op);
    logic [7:0] v;
    case (op)
      3'd0, 3'd1: v = 8'(ADD_LAT - 1);
      3'd2:       v = 8'(MUL_LAT - 1);
      default:    v = 8'(SH_LAT - 1);
    endcase
    return v;
  endfunction

  // Sequencer FSM: accept in IDLE, count down in EXEC, hold result in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_alu_a    <= 32'd0;
      r_alu_b    <= 32'd0;
      r_sel      <= 3'd0;
      r_res_data <= 32'd0;
      r_res_err  <= 1'b0;
      r_op_count <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_alu_a <= req_a;
            r_alu_b <= req_b;
            if (f_illegal(req_op)) begin
              // No ALU work: report the error right away and leave sel untouched.
              r_res_data <= 32'd0;
              r_res_err  <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_sel   <= req_op;
              r_cnt   <= f_lat_m1(req_op);
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (r_cnt == 8'd0) begin
            r_res_data <= mux_out;
            r_res_err  <= 1'b0;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_op_count <= r_op_count + 16'd1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Ready is gated by reset so every output reads zero while reset is held.
  assign req_ready = (r_state == S_IDLE) && rst_n;
  assign res_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign sel       = r_sel;
  assign res_data  = r_res_data;
  assign res_err   = r_res_err;
  assign op_count  = r_op_count;

endmodule
